// File: rtl/rs_syndrome_stream.sv
// Streaming Reed-Solomon syndrome generator: Horner evaluation of NSYM syndromes per run-time-length codeword.
// Latency: syndrome set valid one cycle after the final symbol of a codeword is accepted; back-to-back codewords run without a bubble.
// Backpressure: in_ready drops only for a codeword's final symbol while the previous set is still held in the output register.
module rs_syndrome_stream #(
    parameter int SYMW      = 8,
    parameter int NSYM      = 4,
    parameter int PRIM_POLY = 'h11D,
    parameter int FCR       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SYMW-1:0]      cw_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SYMW-1:0]      in_data,
    input  logic                 in_last,
    output logic                 syn_valid,
    input  logic                 syn_ready,
    output logic [NSYM*SYMW-1:0] syn_data,
    output logic                 syn_nonzero,
    output logic                 syn_len_err
);

    typedef logic [SYMW-1:0]                       sym_t;
    typedef logic [NSYM-1:0][SYMW-1:0]             synset_t;
    typedef logic [NSYM-1:0][SYMW-1:0][SYMW-1:0]   colset_t;
    typedef enum logic {IDLE, ACC} state_t;

    // Low m bits of the generator; the x^m term is implied by the shift-out.
    localparam sym_t POLY_LO = sym_t'(PRIM_POLY);

    // Multiply a field element by alpha.
    function automatic sym_t xtime(input sym_t v);
        return v[SYMW-1] ? ((v << 1) ^ POLY_LO) : (v << 1);
    endfunction

    // Column i of syndrome j's constant multiplier is alpha^(FCR+j) * x^i.
    function automatic colset_t build_cols();
        colset_t c;
        sym_t    v;
        c = '0;
        for (int i = 0; i < SYMW; i++) begin
            v = sym_t'(1) << i;
            for (int k = 0; k < FCR % ((1 << SYMW) - 1); k++) begin
                v = xtime(v);
            end
            for (int j = 0; j < NSYM; j++) begin
                c[j][i] = v;
                v = xtime(v);
            end
        end
        return c;
    endfunction

    localparam colset_t COLS = build_cols();

    state_t  state_q, state_d;
    sym_t    len_q, cnt_q;
    logic    err_q;
    synset_t acc_q;

    sym_t    len_eff, cnt_inc, prod;
    synset_t nxt;
    logic    final_pos, err_d, nz_d, accept, complete;

    // Datapath next values: constant-multiplier XOR networks, completion detection and length check.
    always_comb begin
        len_eff   = (cw_len == '0) ? '1 : cw_len;
        cnt_inc   = cnt_q + sym_t'(1);
        // In IDLE the new codeword's length comes straight from cw_len, so a
        // one-symbol codeword is still held off while the output is occupied.
        final_pos = (state_q == IDLE) ? (len_eff == sym_t'(1)) : (cnt_inc == len_q);
        err_d     = (state_q == IDLE) ? (in_last ^ (len_eff == sym_t'(1)))
                                      : (err_q | (in_last ^ (cnt_inc == len_q)));
        nxt  = '0;
        nz_d = 1'b0;
        prod = '0;
        for (int j = 0; j < NSYM; j++) begin
            prod = '0;
            for (int i = 0; i < SYMW; i++) begin
                if (acc_q[j][i]) begin
                    prod = prod ^ COLS[j][i];
                end
            end
            nxt[j] = (state_q == IDLE) ? in_data : (prod ^ in_data);
            nz_d   = nz_d | (|nxt[j]);
        end
    end

    // FSM next state and handshake.
    always_comb begin
        state_d  = state_q;
        in_ready = ~(final_pos & syn_valid & ~syn_ready);
        accept   = in_valid & in_ready;
        complete = accept & final_pos;
        if (accept) begin
            state_d = final_pos ? IDLE : ACC;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulators, symbol counter, latched length and in_last mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            acc_q <= nxt;
            err_q <= err_d;
            if (state_q == IDLE) begin
                cnt_q <= sym_t'(1);
                len_q <= len_eff;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

    // One-deep output register: load on completion, hold while stalled, clear on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            syn_valid   <= 1'b0;
            syn_data    <= '0;
            syn_nonzero <= 1'b0;
            syn_len_err <= 1'b0;
        end else if (complete) begin
            syn_valid   <= 1'b1;
            syn_data    <= nxt;
            syn_nonzero <= nz_d;
            syn_len_err <= err_d;
        end else if (syn_ready) begin
            syn_valid   <= 1'b0;
            syn_data    <= '0;
            syn_nonzero <= 1'b0;
            syn_len_err <= 1'b0;
        end
    end

endmodule

// File: doc/rs_syndrome_stream.md
Name: rs_syndrome_stream

Overview:
- Parametrised, streaming Reed-Solomon syndrome front end for the RS decoder chain.
- Accepts symbols under valid/ready, with codeword length selected at run time per codeword (shortened codes).
- Computes NSYM syndromes by Horner evaluation and hands them to the Berlekamp stage through a one-deep output register.
- Supports back-to-back codewords with no bubble. Generalises the fixed 4-syndrome, 8-bit, enable-only syndrome path.

Parameters:
- SYMW, 8: symbol width m; field GF(2^m).
- NSYM, 4: number of syndromes (2t), range 2..32.
- PRIM_POLY, 'h11D: field generator polynomial, including the x^m term.
- FCR, 0: first consecutive root; syndrome j evaluates at alpha^(FCR+j).

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- cw_len, in, SYMW: codeword length n in symbols, parity included; sampled on the first symbol of each codeword.
- in_valid, in, 1: input symbol valid.
- in_ready, out, 1: input symbol accepted when in_valid & in_ready.
- in_data, in, SYMW: received symbol, highest-degree symbol first.
- in_last, in, 1: source end-of-codeword marker; checked only, never used for framing.
- syn_valid, out, 1: syndrome set valid.
- syn_ready, in, 1: downstream accepts the set when syn_valid & syn_ready.
- syn_data, out, NSYM*SYMW: S_j in bits [j*SYMW +: SYMW].
- syn_nonzero, out, 1: OR-reduction of all syndromes; qualified by syn_valid.
- syn_len_err, out, 1: in_last mismatch seen in this codeword; qualified by syn_valid.

Behaviour:
- Reset: one clk with rst=1.
  - in_ready=1, syn_valid=0, syn_data=0, syn_nonzero=0, syn_len_err=0.
  - Accumulators=0; FSM=IDLE; symbol counter=0.
  - Reset mid-codeword discards the partial codeword and any held output.
- Field arithmetic: multiply by the constant alpha^(FCR+j) mod PRIM_POLY. Each multiplier is a constant XOR network derived at elaboration; no general multiplier.
- FSM IDLE (awaiting first symbol):
  - On accept: S_j <= in_data for all j.
  - Latch len_q <= cw_len; cw_len==0 means 2^SYMW-1.
  - cnt <= 1; err_q <= in_last ^ (len_q==1).
  - If len_q==1 the codeword completes this cycle, and FSM stays in IDLE. Otherwise go to ACC.
- FSM ACC: on each accept:
  - S_j <= S_j*alpha^(FCR+j) XOR in_data.
  - cnt <= cnt+1.
  - err_q |= in_last XOR (cnt+1 == len_q).
  - When cnt+1==len_q the codeword is complete; return to IDLE.
  - No accept means all state holds.
- Completion: the next-state syndromes, the OR-reduction and the final err_q load the output register.
  - syn_valid rises the cycle after the final symbol is accepted (latency 1).
  - The accumulator is free the same cycle, so the next codeword's first symbol is accepted with no bubble.
- Output register: holds while syn_valid & ~syn_ready. It clears on syn_ready unless reloaded in the same cycle.
- Backpressure:
  - in_ready = ~(final_pos & syn_valid & ~syn_ready).
  - final_pos is true when the next accepted symbol would complete the codeword.
  - in_ready is otherwise 1.
  - in_ready may depend combinationally on syn_ready; no other input-to-output combinational path is allowed.
- Simultaneous drain and completion: syn_ready=1 and completion in the same cycle means the old set leaves and the new set loads; syn_valid stays 1.
- Boundary cases:
  - cw_len changes mid-codeword: ignored.
  - Values of n <= NSYM: processed arithmetically anyway; not flagged.
  - cnt width is SYMW; it never wraps because len_q <= 2^SYMW-1.

Test Plan:
- All-zero codeword, n=255, in_valid continuous, syn_ready=1 → syn_valid pulses for exactly 1 cycle, 1 cycle after the 255th accept; syn_data=0; syn_nonzero=0; syn_len_err=0.
- Single error, n=255, FCR=0, first symbol 0x01, rest 0 → S0=0x01, S1=0x8E, S2=0x47, S3=0xAD; syn_nonzero=1.
- Last symbol 0x05, rest 0 → all four syndromes 0x05.
- Two back-to-back n=10 codewords, syn_ready=0 → in_ready=1 through the first codeword. In the second codeword in_ready drops at the 10th symbol and stays low. Raising syn_ready re-enables in_ready that cycle; the second set appears next cycle.
- n=10 with in_last asserted on symbol 9 → syn_len_err=1. Next codeword, with correct in_last, gives syn_len_err=0.
- rst asserted after 5 of 10 symbols → outputs return to reset values. A fresh all-zero n=10 codeword then yields syn_valid with syn_data=0.
